mpu_ctrl: RTL and testbench
===========================

MPU_CTRL -- requirements
Module: mpu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024: maximum cycles to wait on any sub-unit handshake.
REQ-002 Parameter NREG, default 2**MATRIX_REG_SIZE: number of matrix registers tracked.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid_in  in  1  command present.
REQ-006 cmd_ready_out  out  1  controller accepts the command this cycle.
REQ-007 cmd_op_in  in  2  opcode: NOP=0, LOAD=1, MULT=2, STORE=3.
REQ-008 cmd_dst_in / cmd_src1_in / cmd_src2_in  in  MATRIX_REG_SIZE each  register addresses.
REQ-009 cmd_m_in / cmd_n_in  in  MBITS+1 / NBITS+1  LOAD dimensions.
REQ-010 load_en_out  out  1; load_addr_out  out  MATRIX_REG_SIZE; load_m_out / load_n_out  out  MBITS+1 / NBITS+1  load-unit request.
REQ-011 load_ack_in / load_error_in  in  1  load-unit streaming-ack and error.
REQ-012 mult_start_out  out  1; mult_src1_out / mult_src2_out / mult_dst_out  out  MATRIX_REG_SIZE; mult_done_in  in  1.
REQ-013 store_start_out  out  1; store_addr_out  out  MATRIX_REG_SIZE; store_done_in  in  1.
REQ-014 busy_out  out  1  state != CTRL_IDLE; err_out  out  1  sticky error; err_code_out  out  3  first error cause.

Function
REQ-015 States: CTRL_IDLE, CTRL_LOAD_REQ, CTRL_LOAD_WAIT, CTRL_MULT_WAIT, CTRL_STORE_WAIT.
REQ-016 cmd_ready_out = 1 only in CTRL_IDLE; a command is accepted when cmd_valid_in && cmd_ready_out; NOP is accepted with no effect.
REQ-017 Scoreboard per register: valid bit, m, n; MULT/STORE source must be valid, else err_code 1 (NOT_VALID), stay IDLE.
REQ-018 LOAD: registered outputs load_en_out=1 for exactly one cycle in CTRL_LOAD_REQ with addr/m/n from the command; dst valid bit cleared at accept.
REQ-019 CTRL_LOAD_REQ: load_error_in=1 -> err_code 2 (LOAD_DIM), IDLE; load_ack_in=1 -> CTRL_LOAD_WAIT; otherwise stay (counts toward timeout).
REQ-020 CTRL_LOAD_WAIT: first cycle load_ack_in=0 -> set dst valid with m,n, -> IDLE.
REQ-021 MULT: require src1.n == src2.m, else err_code 3 (DIM_MISMATCH), no start; on pass, mult_start_out=1 one cycle, dst valid cleared, -> CTRL_MULT_WAIT.
REQ-022 CTRL_MULT_WAIT: mult_done_in=1 -> dst valid set with m=src1.m, n=src2.n, -> IDLE.
REQ-023 MULT with dst equal to a source is legal; source dims latched at accept before dst is cleared.
REQ-024 STORE: store_start_out=1 one cycle, -> CTRL_STORE_WAIT; store_done_in=1 -> IDLE; register stays valid.
REQ-025 Timeout: cycle counter clears on every state entry; reaching TIMEOUT in any wait state -> err_code 4 (TIMEOUT), IDLE, pending dst stays invalid.
REQ-026 err_out/err_code_out hold first error until reset; later errors do not overwrite code; controller keeps accepting commands.
REQ-027 Done pulses arriving in a state not waiting for them are ignored.
REQ-028 All start/enable outputs are registered, one-cycle pulses.

Reset
REQ-029 On rst: state CTRL_IDLE; all valid bits 0; counter 0; all start/enable outputs 0; addresses/dims 0; err_out 0, err_code_out 0; cmd_ready_out 1 after release.
REQ-030 rst mid-operation abandons the operation immediately; no start pulse issued in the reset cycle or the cycle after release.

Structure
REQ-031 ctrl_state_t, opcode enum and error-code enum live in mpu_pkg; M, N, MBITS, NBITS, MATRIX_REG_SIZE from global_defs.
REQ-032 Scoreboard is sub-module mpu_scoreboard (NREG entries, one write port, two combinational read ports, async clear).

Verification
REQ-033 LOAD r0 2x3, ack high 6 cycles then low -> one load_en pulse, r0 valid with m=2, n=3, busy low after ack falls.
REQ-034 LOAD r0 2x3, r1 3x2, MULT r2=r0*r1, done after 10 cycles -> one mult_start, r2 valid with 2x2.
REQ-035 MULT r2=r0(2x3)*r0(2x3) -> err_code 3, no mult_start, cmd_ready high next cycle.
REQ-036 STORE of never-loaded r1 -> err_code 1; a following valid STORE still executes; err_code stays 1.
REQ-037 LOAD with load_error_in asserted in request cycle -> err_code 2, r0 invalid; MULT with mult_done never asserted -> err_code 4 exactly TIMEOUT cycles after entering CTRL_MULT_WAIT.
REQ-038 Assert rst asynchronously during CTRL_LOAD_WAIT -> outputs at reset values before next clock edge, all registers invalid.

Source files
------------

// File: rtl/global_defs.sv
// Global matrix geometry shared by the MPU blocks.
package global_defs;
    localparam int M               = 8;
    localparam int N               = 8;
    localparam int MBITS           = $clog2(M);
    localparam int NBITS           = $clog2(N);
    localparam int MATRIX_REG_SIZE = 2;
endpackage

// File: rtl/mpu_pkg.sv
// MPU controller types: FSM states, opcodes, error codes, scoreboard entry.
package mpu_pkg;
    import global_defs::*;

    typedef enum logic [2:0] {
        CTRL_IDLE       = 3'd0,
        CTRL_LOAD_REQ   = 3'd1,
        CTRL_LOAD_WAIT  = 3'd2,
        CTRL_MULT_WAIT  = 3'd3,
        CTRL_STORE_WAIT = 3'd4
    } ctrl_state_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_MULT  = 2'd2,
        OP_STORE = 2'd3
    } opcode_t;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_NOT_VALID    = 3'd1,
        ERR_LOAD_DIM     = 3'd2,
        ERR_DIM_MISMATCH = 3'd3,
        ERR_TIMEOUT      = 3'd4
    } err_code_t;

    typedef struct packed {
        logic             valid;
        logic [MBITS:0]   m;
        logic [NBITS:0]   n;
    } sb_entry_t;
endpackage

// File: rtl/mpu_scoreboard.sv
// Per-register valid/dimension tracking: one write port, two combinational reads.
module mpu_scoreboard
    import global_defs::*;
    import mpu_pkg::*;
#(
    parameter int NREG = 2**MATRIX_REG_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [MATRIX_REG_SIZE-1:0] wr_addr,
    input  logic                       wr_valid,
    input  logic [MBITS:0]             wr_m,
    input  logic [NBITS:0]             wr_n,
    input  logic [MATRIX_REG_SIZE-1:0] rd1_addr,
    output logic                       rd1_valid,
    output logic [MBITS:0]             rd1_m,
    output logic [NBITS:0]             rd1_n,
    input  logic [MATRIX_REG_SIZE-1:0] rd2_addr,
    output logic                       rd2_valid,
    output logic [MBITS:0]             rd2_m,
    output logic [NBITS:0]             rd2_n
);
    sb_entry_t entry [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) entry[i] <= '0;
        end else if (wr_en) begin
            entry[wr_addr] <= '{valid: wr_valid, m: wr_m, n: wr_n};
        end
    end

    assign rd1_valid = entry[rd1_addr].valid;
    assign rd1_m     = entry[rd1_addr].m;
    assign rd1_n     = entry[rd1_addr].n;
    assign rd2_valid = entry[rd2_addr].valid;
    assign rd2_m     = entry[rd2_addr].m;
    assign rd2_n     = entry[rd2_addr].n;
endmodule

// File: rtl/mpu_ctrl.sv
// MPU command controller: sequences LOAD/MULT/STORE sub-units, tracks register
// validity and dimensions, and latches the first error cause.
module mpu_ctrl
    import global_defs::*;
    import mpu_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int NREG    = 2**MATRIX_REG_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid_in,
    output logic                       cmd_ready_out,
    input  logic [1:0]                 cmd_op_in,
    input  logic [MATRIX_REG_SIZE-1:0] cmd_dst_in,
    input  logic [MATRIX_REG_SIZE-1:0] cmd_src1_in,
    input  logic [MATRIX_REG_SIZE-1:0] cmd_src2_in,
    input  logic [MBITS:0]             cmd_m_in,
    input  logic [NBITS:0]             cmd_n_in,
    output logic                       load_en_out,
    output logic [MATRIX_REG_SIZE-1:0] load_addr_out,
    output logic [MBITS:0]             load_m_out,
    output logic [NBITS:0]             load_n_out,
    input  logic                       load_ack_in,
    input  logic                       load_error_in,
    output logic                       mult_start_out,
    output logic [MATRIX_REG_SIZE-1:0] mult_src1_out,
    output logic [MATRIX_REG_SIZE-1:0] mult_src2_out,
    output logic [MATRIX_REG_SIZE-1:0] mult_dst_out,
    input  logic                       mult_done_in,
    output logic                       store_start_out,
    output logic [MATRIX_REG_SIZE-1:0] store_addr_out,
    input  logic                       store_done_in,
    output logic                       busy_out,
    output logic                       err_out,
    output logic [2:0]                 err_code_out
);
    localparam int CW = $clog2(TIMEOUT + 1);

    ctrl_state_t state, state_d;
    opcode_t     op;
    logic        accept;
    logic [CW-1:0] cnt;
    logic        timeout_hit;

    logic                       rd1_valid, rd2_valid;
    logic [MBITS:0]             rd1_m, rd2_m;
    logic [NBITS:0]             rd1_n, rd2_n;
    logic                       sb_wr_en, sb_wr_valid;
    logic [MATRIX_REG_SIZE-1:0] sb_wr_addr;
    logic [MBITS:0]             sb_wr_m;
    logic [NBITS:0]             sb_wr_n;

    // Destination and result dims captured at accept, so dst==src MULT is safe.
    logic [MATRIX_REG_SIZE-1:0] pend_dst;
    logic [MBITS:0]             pend_m;
    logic [NBITS:0]             pend_n;

    logic      load_en_d, mult_start_d, store_start_d;
    logic      err_evt;
    err_code_t err_val;

    assign op            = opcode_t'(cmd_op_in);
    assign cmd_ready_out = (state == CTRL_IDLE);
    assign busy_out      = (state != CTRL_IDLE);
    assign accept        = cmd_valid_in && cmd_ready_out;
    assign timeout_hit   = (cnt == CW'(TIMEOUT - 1));

    mpu_scoreboard #(.NREG(NREG)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (sb_wr_en),
        .wr_addr   (sb_wr_addr),
        .wr_valid  (sb_wr_valid),
        .wr_m      (sb_wr_m),
        .wr_n      (sb_wr_n),
        .rd1_addr  (cmd_src1_in),
        .rd1_valid (rd1_valid),
        .rd1_m     (rd1_m),
        .rd1_n     (rd1_n),
        .rd2_addr  (cmd_src2_in),
        .rd2_valid (rd2_valid),
        .rd2_m     (rd2_m),
        .rd2_n     (rd2_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CTRL_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= (state_d != state || state == CTRL_IDLE) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            CTRL_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD:  state_d = CTRL_LOAD_REQ;
                        OP_MULT:  if (rd1_valid && rd2_valid && int'(rd1_n) == int'(rd2_m))
                                      state_d = CTRL_MULT_WAIT;
                        OP_STORE: if (rd1_valid) state_d = CTRL_STORE_WAIT;
                        default:  state_d = CTRL_IDLE;
                    endcase
                end
            end
            CTRL_LOAD_REQ: begin
                if (load_error_in)    state_d = CTRL_IDLE;
                else if (load_ack_in) state_d = CTRL_LOAD_WAIT;
                else if (timeout_hit) state_d = CTRL_IDLE;
            end
            CTRL_LOAD_WAIT:  if (!load_ack_in || timeout_hit)  state_d = CTRL_IDLE;
            CTRL_MULT_WAIT:  if (mult_done_in || timeout_hit)  state_d = CTRL_IDLE;
            CTRL_STORE_WAIT: if (store_done_in || timeout_hit) state_d = CTRL_IDLE;
            default:         state_d = CTRL_IDLE;
        endcase
    end

    always_comb begin
        load_en_d     = 1'b0;
        mult_start_d  = 1'b0;
        store_start_d = 1'b0;
        sb_wr_en      = 1'b0;
        sb_wr_addr    = pend_dst;
        sb_wr_valid   = 1'b0;
        sb_wr_m       = pend_m;
        sb_wr_n       = pend_n;
        err_evt       = 1'b0;
        err_val       = ERR_NONE;
        case (state)
            CTRL_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD: begin
                            load_en_d  = 1'b1;
                            sb_wr_en   = 1'b1;
                            sb_wr_addr = cmd_dst_in;
                        end
                        OP_MULT: begin
                            if (!(rd1_valid && rd2_valid)) begin
                                err_evt = 1'b1;
                                err_val = ERR_NOT_VALID;
                            end else if (int'(rd1_n) != int'(rd2_m)) begin
                                err_evt = 1'b1;
                                err_val = ERR_DIM_MISMATCH;
                            end else begin
                                mult_start_d = 1'b1;
                                sb_wr_en     = 1'b1;
                                sb_wr_addr   = cmd_dst_in;
                            end
                        end
                        OP_STORE: begin
                            if (!rd1_valid) begin
                                err_evt = 1'b1;
                                err_val = ERR_NOT_VALID;
                            end else begin
                                store_start_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CTRL_LOAD_REQ: begin
                if (load_error_in) begin
                    err_evt = 1'b1;
                    err_val = ERR_LOAD_DIM;
                end else if (!load_ack_in && timeout_hit) begin
                    err_evt = 1'b1;
                    err_val = ERR_TIMEOUT;
                end
            end
            CTRL_LOAD_WAIT: begin
                if (!load_ack_in) begin
                    sb_wr_en    = 1'b1;
                    sb_wr_valid = 1'b1;
                end else if (timeout_hit) begin
                    err_evt = 1'b1;
                    err_val = ERR_TIMEOUT;
                end
            end
            CTRL_MULT_WAIT: begin
                if (mult_done_in) begin
                    sb_wr_en    = 1'b1;
                    sb_wr_valid = 1'b1;
                end else if (timeout_hit) begin
                    err_evt = 1'b1;
                    err_val = ERR_TIMEOUT;
                end
            end
            CTRL_STORE_WAIT: begin
                if (!store_done_in && timeout_hit) begin
                    err_evt = 1'b1;
                    err_val = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_en_out     <= 1'b0;
            load_addr_out   <= '0;
            load_m_out      <= '0;
            load_n_out      <= '0;
            mult_start_out  <= 1'b0;
            mult_src1_out   <= '0;
            mult_src2_out   <= '0;
            mult_dst_out    <= '0;
            store_start_out <= 1'b0;
            store_addr_out  <= '0;
            pend_dst        <= '0;
            pend_m          <= '0;
            pend_n          <= '0;
            err_out         <= 1'b0;
            err_code_out    <= '0;
        end else begin
            load_en_out     <= load_en_d;
            mult_start_out  <= mult_start_d;
            store_start_out <= store_start_d;
            if (load_en_d) begin
                load_addr_out <= cmd_dst_in;
                load_m_out    <= cmd_m_in;
                load_n_out    <= cmd_n_in;
            end
            if (mult_start_d) begin
                mult_src1_out <= cmd_src1_in;
                mult_src2_out <= cmd_src2_in;
                mult_dst_out  <= cmd_dst_in;
            end
            if (store_start_d) store_addr_out <= cmd_src1_in;
            if (load_en_d || mult_start_d) begin
                pend_dst <= cmd_dst_in;
                pend_m   <= load_en_d ? cmd_m_in : rd1_m;
                pend_n   <= load_en_d ? cmd_n_in : rd2_n;
            end
            if (err_evt && !err_out) begin
                err_out      <= 1'b1;
                err_code_out <= err_val;
            end
        end
    end
endmodule

// File: tb/tb_mpu_ctrl.sv
// Directed bench for mpu_ctrl: LOAD/MULT/STORE flows, error codes, timeout, async reset.
module tb_mpu_ctrl;
    import global_defs::*;

    localparam int TO = 16;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       cmd_valid_in = 1'b0;
    logic                       cmd_ready_out;
    logic [1:0]                 cmd_op_in = '0;
    logic [MATRIX_REG_SIZE-1:0] cmd_dst_in = '0, cmd_src1_in = '0, cmd_src2_in = '0;
    logic [MBITS:0]             cmd_m_in = '0;
    logic [NBITS:0]             cmd_n_in = '0;
    logic                       load_en_out;
    logic [MATRIX_REG_SIZE-1:0] load_addr_out;
    logic [MBITS:0]             load_m_out;
    logic [NBITS:0]             load_n_out;
    logic                       load_ack_in = 1'b0, load_error_in = 1'b0;
    logic                       mult_start_out;
    logic [MATRIX_REG_SIZE-1:0] mult_src1_out, mult_src2_out, mult_dst_out;
    logic                       mult_done_in = 1'b0;
    logic                       store_start_out;
    logic [MATRIX_REG_SIZE-1:0] store_addr_out;
    logic                       store_done_in = 1'b0;
    logic                       busy_out, err_out;
    logic [2:0]                 err_code_out;

    int n_chk = 0, n_fail = 0;
    int n_load = 0, n_mult = 0;
    int snap;

    mpu_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out), .cmd_op_in(cmd_op_in),
        .cmd_dst_in(cmd_dst_in), .cmd_src1_in(cmd_src1_in), .cmd_src2_in(cmd_src2_in),
        .cmd_m_in(cmd_m_in), .cmd_n_in(cmd_n_in),
        .load_en_out(load_en_out), .load_addr_out(load_addr_out),
        .load_m_out(load_m_out), .load_n_out(load_n_out),
        .load_ack_in(load_ack_in), .load_error_in(load_error_in),
        .mult_start_out(mult_start_out), .mult_src1_out(mult_src1_out),
        .mult_src2_out(mult_src2_out), .mult_dst_out(mult_dst_out), .mult_done_in(mult_done_in),
        .store_start_out(store_start_out), .store_addr_out(store_addr_out),
        .store_done_in(store_done_in),
        .busy_out(busy_out), .err_out(err_out), .err_code_out(err_code_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en_out)    n_load <= n_load + 1;
        if (mult_start_out) n_mult <= n_mult + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int op, input int dst, input int s1, input int s2,
                        input int m, input int n);
        cmd_op_in    = 2'(op);
        cmd_dst_in   = MATRIX_REG_SIZE'(dst);
        cmd_src1_in  = MATRIX_REG_SIZE'(s1);
        cmd_src2_in  = MATRIX_REG_SIZE'(s2);
        cmd_m_in     = (MBITS+1)'(m);
        cmd_n_in     = (NBITS+1)'(n);
        cmd_valid_in = 1'b1;
        tick();
        cmd_valid_in = 1'b0;
    endtask

    task automatic do_load(input int dst, input int m, input int n);
        send(1, dst, 0, 0, m, n);
        load_ack_in = 1'b1;
        tick();
        load_ack_in = 1'b0;
        tick();
    endtask

    task automatic do_mult(input int dst, input int s1, input int s2);
        send(2, dst, s1, s2, 0, 0);
        mult_done_in = 1'b1;
        tick();
        mult_done_in = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_busy", busy_out, 0);
        chk("rst_ready", cmd_ready_out, 1);
        chk("rst_err", err_out, 0);
        chk("rst_code", err_code_out, 0);
        chk("rst_pulses", {load_en_out, mult_start_out, store_start_out}, 0);
        chk("rst_addr", {load_addr_out, mult_dst_out, store_addr_out}, 0);

        // LOAD r0 2x3 with a 6-cycle ack
        send(0, 3, 3, 3, 0, 0);
        chk("nop_busy", busy_out, 0);
        snap = n_load;
        send(1, 0, 0, 0, 2, 3);
        chk("ld_en", load_en_out, 1);
        chk("ld_fields", {load_addr_out, load_m_out, load_n_out}, {2'd0, 4'd2, 4'd3});
        chk("ld_ready", cmd_ready_out, 0);
        load_ack_in = 1'b1;
        repeat (6) tick();
        chk("ld_en_gone", load_en_out, 0);
        chk("ld_busy_ack", busy_out, 1);
        load_ack_in = 1'b0;
        tick();
        chk("ld_idle", busy_out, 0);
        chk("ld_pulses", n_load - snap, 1);
        send(3, 0, 0, 0, 0, 0);
        chk("st_r0_start", store_start_out, 1);
        chk("st_r0_addr", store_addr_out, 0);
        store_done_in = 1'b1;
        tick();
        store_done_in = 1'b0;
        chk("st_r0_idle", busy_out, 0);
        chk("st_r0_noerr", err_out, 0);

        // MULT r2 = r0(2x3) * r1(3x2), done after 10 cycles
        do_load(1, 3, 2);
        snap = n_mult;
        send(2, 2, 0, 1, 0, 0);
        chk("mu_start", mult_start_out, 1);
        chk("mu_regs", {mult_src1_out, mult_src2_out, mult_dst_out}, {2'd0, 2'd1, 2'd2});
        repeat (10) tick();
        chk("mu_wait", busy_out, 1);
        mult_done_in = 1'b1;
        tick();
        mult_done_in = 1'b0;
        chk("mu_idle", busy_out, 0);
        chk("mu_pulses", n_mult - snap, 1);
        // r2 must be 2x2: r2*r2 and r1(3x2)*r2 both legal
        send(2, 3, 2, 2, 0, 0);
        chk("r2sq_start", mult_start_out, 1);
        mult_done_in = 1'b1;
        tick();
        mult_done_in = 1'b0;
        send(2, 3, 1, 2, 0, 0);
        chk("r1r2_start", mult_start_out, 1);
        mult_done_in = 1'b1;
        tick();
        mult_done_in = 1'b0;
        chk("r2_noerr", err_out, 0);

        // dimension mismatch r0(2x3)*r0(2x3)
        snap = n_mult;
        send(2, 2, 0, 0, 0, 0);
        chk("mm_nostart", mult_start_out, 0);
        chk("mm_code", {err_out, err_code_out}, {1'b1, 3'd3});
        chk("mm_ready", cmd_ready_out, 1);
        tick();
        chk("mm_pulses", n_mult - snap, 0);

        // STORE of unloaded r1, then a valid STORE; first code holds
        do_reset();
        send(3, 0, 1, 0, 0, 0);
        chk("nv_nostart", store_start_out, 0);
        chk("nv_code", {err_out, err_code_out}, {1'b1, 3'd1});
        chk("nv_ready", cmd_ready_out, 1);
        do_load(0, 2, 3);
        send(3, 0, 0, 0, 0, 0);
        chk("nv_st_start", store_start_out, 1);
        store_done_in = 1'b1;
        tick();
        store_done_in = 1'b0;
        chk("nv_st_idle", busy_out, 0);
        send(2, 2, 0, 0, 0, 0);
        chk("nv_code_kept", err_code_out, 1);

        // MULT with no done: timeout exactly TO cycles after entering wait
        do_reset();
        do_load(0, 2, 3);
        do_load(1, 3, 2);
        send(2, 2, 0, 1, 0, 0);
        chk("to_start", mult_start_out, 1);
        repeat (TO - 1) tick();
        chk("to_before", {busy_out, err_out}, {1'b1, 1'b0});
        tick();
        chk("to_after", {busy_out, err_out, err_code_out}, {1'b0, 1'b1, 3'd4});
        mult_done_in = 1'b1;
        tick();
        mult_done_in = 1'b0;
        chk("late_done", busy_out, 0);
        send(3, 0, 2, 0, 0, 0);
        chk("to_dst_inv", store_start_out, 0);

        // LOAD error in request cycle
        do_reset();
        send(1, 0, 0, 0, 2, 3);
        load_error_in = 1'b1;
        tick();
        load_error_in = 1'b0;
        chk("le_code", {busy_out, err_out, err_code_out}, {1'b0, 1'b1, 3'd2});
        send(3, 0, 0, 0, 0, 0);
        chk("le_r0_inv", store_start_out, 0);

        // async reset during LOAD_WAIT
        do_reset();
        do_load(1, 3, 2);
        send(1, 3, 0, 0, 4, 5);
        load_ack_in = 1'b1;
        tick();
        chk("ar_wait", {busy_out, load_addr_out}, {1'b1, 2'd3});
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", {busy_out, cmd_ready_out}, {1'b0, 1'b1});
        chk("ar_outs", {load_en_out, load_addr_out, load_m_out, load_n_out}, 0);
        chk("ar_err", {err_out, err_code_out}, 0);
        tick();
        rst = 1'b0;
        load_ack_in = 1'b0;
        send(3, 0, 1, 0, 0, 0);
        chk("ar_r1_inv", {store_start_out, err_code_out}, {1'b0, 3'd1});
        send(3, 0, 3, 0, 0, 0);
        chk("ar_r3_inv", store_start_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
